serial_bitstream_tx: RTL

SERIAL_BITSTREAM_TX -- requirements
Module: serial_bitstream_tx

---
 rtl/serial_tx_pkg.sv | 23 ++
 rtl/serial_bitstream_tx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial bitstream transmitter: FSM state
// encoding and the default parameter values used by the top module.
package serial_tx_pkg;

    // Default word width in bits (legal range 2..32).
    localparam int DEFAULT_DATA_W    = 8;
    // 1 = bit DATA_W-1 leaves first, 0 = bit 0 leaves first.
    localparam int DEFAULT_MSB_FIRST = 1;
    // Line level driven on bit_out while no data bit is valid.
    localparam int DEFAULT_IDLE_BIT  = 0;

    // IDLE: shifter empty. SHIFT: shifter emitting one bit per cycle.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

    // Bit counter width for a given word width (at least one bit).
    function automatic int cnt_width(input int data_w);
        return (data_w <= 2) ? 1 : $clog2(data_w);
    endfunction

endpackage : serial_tx_pkg

// File: rtl/serial_bitstream_tx.sv
// Parallel-to-serial transmitter. Words enter through a valid/ready port,
// pass through an optional one-entry holding register, and are shifted out
// one bit per cycle. Back-to-back words form a gap-free stream; when the
// stream runs dry a one-cycle gap pulse marks the transition to idle.
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready is NOT hold_full, so it depends only on registered
// state. The source may assert in_valid at any time and should hold in_data
// stable until the transfer. While reset is high no transfer occurs even
// though in_ready reads 1.
module serial_bitstream_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MSB_FIRST = DEFAULT_MSB_FIRST,
    parameter int IDLE_BIT  = DEFAULT_IDLE_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              word_start,
    output logic              gap,
    output logic [0:0]        dbg_state
);

    // Legacy-compatible state constants, tied to the package enum.
    localparam logic [0:0] ST_IDLE  = 1'(IDLE);
    localparam logic [0:0] ST_SHIFT = 1'(SHIFT);

    localparam int              CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic            IDLE_LVL = (IDLE_BIT != 0);
    localparam bit              SEND_MSB = (MSB_FIRST != 0);

    // Reject unsupported word widths at elaboration time.
    if (DATA_W < 2 || DATA_W > 32) begin : g_bad_width
        $error("serial_bitstream_tx: DATA_W must be in 2..32");
    end

    // Registered state.
    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0]  bit_cnt_d;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [DATA_W-1:0] hold_q;
    logic              hold_full_q;
    logic              gap_q;

    // Per-edge decisions.
    logic              accept;
    logic              shifter_free;
    logic              load_hold;
    logic              load_bypass;
    logic              load_any;
    logic              write_hold;
    logic              leave_shift;
    logic [DATA_W-1:0] shreg_shifted;
    logic              head_bit;

    assign in_ready = ~hold_full_q;
    assign accept   = in_valid & in_ready;

    // The shifter can take a new word when it is empty or on its last bit.
    assign shifter_free = (state_q == ST_IDLE) ||
                          ((state_q == ST_SHIFT) && (bit_cnt_q == LAST_CNT));

    // A held word always has priority; otherwise the incoming word bypasses
    // the holding register so an idle line starts on the very next cycle.
    assign load_hold   = shifter_free & hold_full_q;
    assign load_bypass = shifter_free & ~hold_full_q & accept;
    assign load_any    = load_hold | load_bypass;

    // Words that cannot go straight into the shifter are parked.
    assign write_hold  = accept & (~shifter_free | load_hold);

    // Last bit finished and nothing to follow: the stream goes idle.
    assign leave_shift = (state_q == ST_SHIFT) & shifter_free & ~load_any;

    // One-bit advance toward the transmit end of the shifter.
    assign shreg_shifted = SEND_MSB ? {shreg_q[DATA_W-2:0], 1'b0}
                                    : {1'b0, shreg_q[DATA_W-1:1]};

    assign head_bit = SEND_MSB ? shreg_q[DATA_W-1] : shreg_q[0];

    // Next-state logic for the FSM, bit counter and shifter.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        if (load_hold) begin
            state_d   = ST_SHIFT;
            bit_cnt_d = '0;
            shreg_d   = hold_q;
        end else if (load_bypass) begin
            state_d   = ST_SHIFT;
            bit_cnt_d = '0;
            shreg_d   = in_data;
        end else if (leave_shift) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
        end else if (state_q == ST_SHIFT) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            shreg_d   = shreg_shifted;
        end
    end

    // FSM, bit counter and shifter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    // One-entry holding register: filled by a parked word, drained by a load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            if (write_hold) begin
                hold_q      <= in_data;
                hold_full_q <= 1'b1;
            end else if (load_hold) begin
                hold_full_q <= 1'b0;
            end
        end
    end

    // Gap pulse for the cycle after the stream drops back to idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_q <= 1'b0;
        end else begin
            gap_q <= leave_shift;
        end
    end

    // Outputs are decoded from registers only; in_data never reaches bit_out.
    assign bit_valid  = (state_q == ST_SHIFT);
    assign bit_out    = (state_q == ST_SHIFT) ? head_bit : IDLE_LVL;
    assign word_start = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
    assign gap        = gap_q;
    assign dbg_state  = state_q;

endmodule : serial_bitstream_tx
